// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding a UART transmitter.
// Host writes bytes, and the block launches each one with a one-cycle start
// pulse. It then waits for done_tx before launching the next byte.
// Optional feature: define UART_TX_FIFO_FLUSH_EN to add a flush input that
// clears the queue without disturbing a frame already in flight.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef UART_TX_FIFO_FLUSH_EN
  input  logic              flush,
`endif
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       count,
  output logic              overflow,
  output logic [DATA_W-1:0] tx_data_in,
  output logic              start,
  input  logic              tx_active,
  input  logic              done_tx
);

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              push, pop, clr;
  logic [AW:0]       count_nxt;

`ifdef UART_TX_FIFO_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // full is the pre-edge flag, so a write while full is dropped even if a pop
  // frees a slot on the same edge.
  assign push = wr_en && !full && !clr;
  assign pop  = (state == IDLE) && !empty && !tx_active;

  // Post-edge occupancy; full/empty/count are all registered from this.
  always_comb begin
    count_nxt = count;
    if (clr)
      count_nxt = '0;
    else if (push && !pop)
      count_nxt = count + (AW+1)'(1);
    else if (pop && !push)
      count_nxt = count - (AW+1)'(1);
  end

  // Byte storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy flags and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_en && full) overflow <= 1'b1;
      if (clr) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Launch FSM: pop one byte, pulse start, then hold the byte until done_tx.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      start      <= 1'b0;
      tx_data_in <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            tx_data_in <= mem[rd_ptr];
            start      <= 1'b1;
            state      <= LAUNCH;
          end
        end
        LAUNCH: begin
          start <= 1'b0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_tx) state <= IDLE;
        end
        default: begin
          start <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench with a queue-based reference model.
// A simple transmitter model answers each start pulse with done_tx ten
// cycles later. Outputs are compared on every falling edge.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;
  localparam int DW    = 8;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          full, empty, overflow, start;
  logic [AW:0]   count;
  logic [DW-1:0] tx_data_in;
  logic          xbusy = 1'b0, hold = 1'b0, done_tx = 1'b0;
  wire           tx_active = xbusy | hold;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
`ifdef UART_TX_FIFO_FLUSH_EN
    .flush(1'b0),
`endif
    .wr_en(wr_en), .wr_data(wr_data), .full(full), .empty(empty),
    .count(count), .overflow(overflow), .tx_data_in(tx_data_in),
    .start(start), .tx_active(tx_active), .done_tx(done_tx)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk); #2;
  endtask

  // Transmitter model: done_tx pulses 10 cycles after start is seen.
  int tmr = 0;
  initial forever begin
    @(posedge clk); #1;
    if (tmr > 0) begin
      tmr--;
      if (tmr == 0) begin done_tx = 1'b1; xbusy = 1'b0; end
    end else done_tx = 1'b0;
    if (start === 1'b1) begin xbusy = 1'b1; tmr = 10; end
  end

  // Reference model: byte queue plus launch/busy tracking from the rules.
  logic [DW-1:0] m_q[$];
  logic [DW-1:0] m_data = '0;
  bit m_ovf = 0, m_start = 0, m_busy = 0;
  always @(posedge clk) begin
    bit can_pop, was_full;
    cyc++;
    if (rst) begin
      m_q.delete(); m_ovf = 0; m_start = 0; m_busy = 0; m_data = '0;
    end else begin
      can_pop  = !m_start && !m_busy && (m_q.size() > 0) && !tx_active;
      was_full = (m_q.size() == DEPTH);
      if (m_start) begin m_start = 0; m_busy = 1; end
      else if (m_busy) begin if (done_tx) m_busy = 0; end
      else if (can_pop) begin m_data = m_q.pop_front(); m_start = 1; end
      if (wr_en) begin
        if (was_full) m_ovf = 1;
        else m_q.push_back(wr_data);
      end
    end
  end

  // Every-cycle comparison plus logs of launches and done pulses.
  logic [DW-1:0] sent[$];
  int start_cyc[$], done_cyc[$];
  always @(negedge clk) begin
    if (chk_on) begin
      chk("count", count, m_q.size());
      chk("empty", empty, m_q.size() == 0);
      chk("full", full, m_q.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("start", start, m_start);
      chk("tx_data_in", tx_data_in, m_data);
    end
    if (start === 1'b1) begin sent.push_back(tx_data_in); start_cyc.push_back(cyc); end
    if (done_tx) done_cyc.push_back(cyc);
  end

  task automatic write(input logic [DW-1:0] d);
    wr_en = 1'b1; wr_data = d; tick(); wr_en = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int n = 0;
    while (start !== 1'b1 && n < budget) begin tick(); n++; end
    chk("wait_start", start, 1'b1);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (!(empty === 1'b1 && start === 1'b0 && tx_active === 1'b0 && done_tx === 1'b0)
           && n < budget) begin tick(); n++; end
    chk("drain", empty === 1'b1 && tx_active === 1'b0, 1'b1);
    tick();
  endtask

  task automatic chk_sent(input string nm, input logic [DW-1:0] exp[$]);
    chk({nm, "_n"}, sent.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk(nm, (i < sent.size()) ? sent[i] : 8'hxx, exp[i]);
    sent.delete();
  endtask

  initial begin
    logic [DW-1:0] exp[$];
    // Reset, then check reset state.
    rst = 1'b1; tick(); chk_on = 1'b1; tick();
    chk("rst_count", count, 0); chk("rst_empty", empty, 1);
    chk("rst_full", full, 0); chk("rst_ovf", overflow, 0);
    chk("rst_start", start, 0); chk("rst_txd", tx_data_in, 0);
    rst = 1'b0; tick();

    // Single write latency.
    wr_en = 1'b1; wr_data = 8'hA5; tick(); wr_en = 1'b0;
    chk("t1_empty_c1", empty, 0); chk("t1_count_c1", count, 1); chk("t1_start_c1", start, 0);
    tick();
    chk("t1_start_c2", start, 1); chk("t1_txd_c2", tx_data_in, 8'hA5);
    tick();
    chk("t1_start_c3", start, 0); chk("t1_count_c3", count, 0);
    wait_drain(40);
    exp = '{8'hA5}; chk_sent("t1_byte", exp);

    // Burst ordering with back-to-back frame timing.
    start_cyc.delete(); done_cyc.delete();
    for (int i = 1; i <= 5; i++) write(DW'(i));
    wait_drain(120);
    exp = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05}; chk_sent("t2_byte", exp);
    chk("t2_ndone", done_cyc.size(), 5);
    for (int i = 1; i < 5; i++)
      if (i < start_cyc.size() && i - 1 < done_cyc.size())
        chk("t2_gap", start_cyc[i] - done_cyc[i-1], 2);

    // Pointer wrap: keep a few bytes queued while 40 go through.
    exp.delete();
    for (int i = 0; i < 40; i++) exp.push_back(DW'(i * 7 + 3));
    for (int i = 0; i < 5; i++) write(exp[i]);
    for (int i = 5; i < 40; i++) begin
      wait_start(30);
      chk("t4_occ", (count >= 3 && count <= 6), 1);
      write(exp[i]);
    end
    wait_drain(120);
    chk_sent("t4_byte", exp);

    // Fill and overflow.
    rst = 1'b1; tick(); rst = 1'b0; hold = 1'b1;
    exp.delete();
    for (int i = 0; i < 16; i++) begin exp.push_back(DW'(8'h40 + i)); write(exp[i]); end
    chk("t3_full", full, 1); chk("t3_count", count, 16); chk("t3_ovf0", overflow, 0);
    write(8'hEE);
    chk("t3_count17", count, 16); chk("t3_ovf1", overflow, 1);
    tick(); tick();
    hold = 1'b0;
    wait_drain(16 * 12 + 40);
    chk_sent("t3_byte", exp);
    chk("t3_ovf_held", overflow, 1);

    // Simultaneous write and pop.
    hold = 1'b1;
    write(8'h50); write(8'h51); write(8'h52); tick();
    chk("t5_count_pre", count, 3);
    hold = 1'b0; wr_en = 1'b1; wr_data = 8'h53; tick(); wr_en = 1'b0;
    chk("t5_count", count, 3); chk("t5_start", start, 1); chk("t5_txd", tx_data_in, 8'h50);

    // Reset during WAIT_DONE.
    write(8'h54);
    chk("t6_count_pre", count, 4); chk("t6_start_pre", start, 0);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("t6_count", count, 0); chk("t6_empty", empty, 1);
    chk("t6_start", start, 0); chk("t6_ovf", overflow, 0);
    begin
      int n = 0;
      while (tx_active !== 1'b0 && n < 30) begin tick(); n++; end
      chk("t6_txidle", tx_active, 0);
    end
    tick();
    sent.delete();
    write(8'h3C);
    chk("t6_empty_c1", empty, 0); tick();
    chk("t6_start_c2", start, 1); chk("t6_txd_c2", tx_data_in, 8'h3C);
    wait_drain(40);
    exp = '{8'h3C}; chk_sent("t6_byte", exp);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
